// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter states, command/response bytes
// and the microsecond-to-cycle conversion used to size all timing constants.
package ps2_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_START,
      ST_REQ,
      ST_SHIFT,
      ST_ACK,
      ST_RELEASE,
      ST_DONE,
      ST_FAIL
   } ps2_tx_state_t;

   localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
   localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;
   localparam logic [7:0] PS2_SC_BREAK    = 8'hF0;

   // Falls 1..10 carry d0..d7, parity, stop; fall 11 is the device ACK.
   localparam logic [3:0] PS2_LAST_DATA_FALL = 4'd10;

   function automatic int unsigned us_to_cyc(input int unsigned freq_hz,
                                             input int unsigned us);
      return (freq_hz / 1_000_000) * us;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins with falling-edge
// detection on the synchronized levels; shared with the scan-code receiver.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic clk_sync,
   output logic data_sync,
   output logic clk_fall,
   output logic data_fall
);

   logic [1:0] clk_meta;
   logic [1:0] data_meta;
   logic       clk_prev;
   logic       data_prev;

   // Reset to the idle-high line level so leaving reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_meta  <= '1;
         data_meta <= '1;
         clk_prev  <= 1'b1;
         data_prev <= 1'b1;
      end else begin
         clk_meta  <= {clk_meta[0], ps2_clk};
         data_meta <= {data_meta[0], ps2_data};
         clk_prev  <= clk_meta[1];
         data_prev <= data_meta[1];
      end
   end

   assign clk_sync  = clk_meta[1];
   assign data_sync = data_meta[1];
   assign clk_fall  = clk_prev & ~clk_meta[1];
   assign data_fall = data_prev & ~data_meta[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift one command
// byte out on device clock falls and check the device ACK bit.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ    = 50_000_000,
   parameter int unsigned INHIBIT_US     = 120,
   parameter int unsigned REQ_TIMEOUT_US = 15000,
   parameter int unsigned BIT_TIMEOUT_US = 2000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned INH_CYC   = us_to_cyc(CLK_FREQ_HZ, INHIBIT_US);
   localparam int unsigned START_CYC = us_to_cyc(CLK_FREQ_HZ, 1);
   localparam int unsigned REQ_TO    = us_to_cyc(CLK_FREQ_HZ, REQ_TIMEOUT_US);
   localparam int unsigned BIT_TO    = us_to_cyc(CLK_FREQ_HZ, BIT_TIMEOUT_US);
   localparam int unsigned TW        = $clog2(REQ_TO + 1);

   localparam logic [TW-1:0] INH_LAST   = TW'(INH_CYC - 1);
   localparam logic [TW-1:0] START_LAST = TW'(START_CYC - 1);
   localparam logic [TW-1:0] REQ_LIMIT  = TW'(REQ_TO);
   localparam logic [TW-1:0] BIT_LIMIT  = TW'(BIT_TO);

   ps2_tx_state_t state, state_n;
   logic [10:0]   sh, sh_n;
   logic [3:0]    bit_cnt, bit_cnt_n;
   logic [TW-1:0] timer, timer_n;
   logic          err_flag, err_flag_n;
   logic          clk_oe_n, data_oe_n, busy_n, done_n, err_n;

   logic clk_sync, data_sync, clk_fall;
   logic unused_data_fall;

   ps2_line_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .ps2_clk   (ps2_clk_in),
      .ps2_data  (ps2_data_in),
      .clk_sync  (clk_sync),
      .data_sync (data_sync),
      .clk_fall  (clk_fall),
      .data_fall (unused_data_fall)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sh          <= '0;
         bit_cnt     <= '0;
         timer       <= '0;
         err_flag    <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_busy     <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
      end else begin
         state       <= state_n;
         sh          <= sh_n;
         bit_cnt     <= bit_cnt_n;
         timer       <= timer_n;
         err_flag    <= err_flag_n;
         ps2_clk_oe  <= clk_oe_n;
         ps2_data_oe <= data_oe_n;
         tx_busy     <= busy_n;
         tx_done     <= done_n;
         tx_err      <= err_n;
      end
   end

   always_comb begin
      state_n    = state;
      sh_n       = sh;
      bit_cnt_n  = bit_cnt;
      timer_n    = timer + 1'b1;
      err_flag_n = err_flag;
      data_oe_n  = ps2_data_oe;

      unique case (state)
         ST_IDLE: begin
            timer_n = '0;
            if (tx_start) begin
               // Start bit sits in sh[0] and is dropped when the clock is released.
               sh_n       = {1'b1, ~^tx_data, tx_data, 1'b0};
               bit_cnt_n  = '0;
               err_flag_n = 1'b0;
               state_n    = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (timer == INH_LAST) begin
               timer_n   = '0;
               data_oe_n = 1'b1;
               state_n   = ST_START;
            end
         end
         ST_START: begin
            if (timer == START_LAST) begin
               timer_n = '0;
               sh_n    = {1'b1, sh[10:1]};
               state_n = ST_REQ;
            end
         end
         ST_REQ: begin
            if (clk_fall) begin
               data_oe_n = ~sh[0];
               sh_n      = {1'b1, sh[10:1]};
               bit_cnt_n = 4'd1;
               timer_n   = '0;
               state_n   = ST_SHIFT;
            end else if (timer > REQ_LIMIT) begin
               state_n = ST_FAIL;
            end
         end
         ST_SHIFT: begin
            if (clk_fall) begin
               data_oe_n = ~sh[0];
               sh_n      = {1'b1, sh[10:1]};
               bit_cnt_n = bit_cnt + 4'd1;
               timer_n   = '0;
               if (bit_cnt_n == PS2_LAST_DATA_FALL) state_n = ST_ACK;
            end else if (timer > BIT_LIMIT) begin
               state_n = ST_FAIL;
            end
         end
         ST_ACK: begin
            if (clk_fall) begin
               err_flag_n = data_sync;
               timer_n    = '0;
               state_n    = ST_RELEASE;
            end else if (timer > BIT_LIMIT) begin
               state_n = ST_FAIL;
            end
         end
         ST_RELEASE: begin
            if (clk_sync && data_sync) state_n = ST_DONE;
            else if (timer > BIT_LIMIT) state_n = ST_FAIL;
         end
         ST_DONE: state_n = ST_IDLE;
         ST_FAIL: begin
            err_flag_n = 1'b1;
            state_n    = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase

      // Line enables follow the next state so they change with it, glitch-free.
      if (!(state_n inside {ST_START, ST_REQ, ST_SHIFT})) data_oe_n = 1'b0;
      clk_oe_n = (state_n == ST_INHIBIT) || (state_n == ST_START);
      busy_n   = !(state_n inside {ST_IDLE, ST_DONE});
      done_n   = (state_n == ST_DONE);
      err_n    = done_n && err_flag_n;
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
module tb_ps2_host_tx;

   localparam int REQ_TO = 15000;
   localparam int INH    = 120;
   localparam int H      = 15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic       tx_start = 1'b0;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       tx_busy, tx_done, tx_err;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;

   int pass_count = 0;
   int check_count = 0;
   int done_count = 0;
   int err_count = 0;
   logic last_err = 1'b0;

   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.CLK_FREQ_HZ(1_000_000)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_done) begin
         done_count = done_count + 1;
         last_err   = tx_err;
      end
      if (tx_err) err_count = err_count + 1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      tx_data  = 8'hED;
      tx_start = 1'b1;
      cyc(3);
      check_count++;
      if ({ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err} !== 5'b00000)
         $display("FAIL reset_outputs: got %b expected 00000",
                  {ps2_clk_oe, ps2_data_oe, tx_busy, tx_done, tx_err});
      else pass_count++;
      rst      = 1'b0;
      tx_start = 1'b0;
      cyc(2);
      check_count++;
      if (tx_busy !== 1'b0) $display("FAIL reset_wins_start: busy got %b expected 0", tx_busy);
      else pass_count++;
      check_count++;
      if (done_count !== 0) $display("FAIL reset_no_done: done pulses got %0d expected 0", done_count);
      else pass_count++;
   endtask

   // Full transfer with the device model. inject_fall pulses a competing
   // tx_start during that bit; rst_fall resets the DUT during that bit.
   task automatic run_xfer(input logic [7:0] d, input logic exp_par, input bit ack,
                           input int inject_fall, input int rst_fall, input string name);
      int         n;
      int         done_before;
      int         err_before;
      logic [9:0] rx;
      logic [9:0] exp_frame;
      logic       clk_oe_seen;
      exp_frame   = {1'b1, exp_par, d};
      rx          = '0;
      clk_oe_seen = 1'b0;
      done_before = done_count;
      err_before  = err_count;

      tx_data  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      check_count++;
      if (tx_busy !== 1'b1) $display("FAIL %s busy_on_start: got %b expected 1", name, tx_busy);
      else pass_count++;

      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      check_count++;
      if (n !== INH) $display("FAIL %s inhibit_len: got %0d expected %0d", name, n, INH);
      else pass_count++;
      check_count++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b11)
         $display("FAIL %s start_bit: oe got %b expected 11", name, {ps2_clk_oe, ps2_data_oe});
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ({ps2_clk_oe, ps2_data_oe} !== 2'b01)
         $display("FAIL %s request_to_send: oe got %b expected 01", name, {ps2_clk_oe, ps2_data_oe});
      else pass_count++;

      cyc(10);
      for (int i = 1; i <= 10; i++) begin
         dev_clk_low = 1'b1;
         cyc(5);
         if (i == inject_fall) begin
            tx_data  = 8'h55;
            tx_start = 1'b1;
            cyc(1);
            tx_start = 1'b0;
         end else begin
            cyc(1);
         end
         if (i == rst_fall) begin
            rst = 1'b1;
            cyc(1);
            rst = 1'b0;
            check_count++;
            if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000)
               $display("FAIL %s reset_release: clk_oe,data_oe,busy got %b expected 000",
                        name, {ps2_clk_oe, ps2_data_oe, tx_busy});
            else pass_count++;
            dev_clk_low = 1'b0;
            cyc(30);
            check_count++;
            if (done_count !== done_before)
               $display("FAIL %s reset_no_done: done pulses got %0d expected %0d",
                        name, done_count, done_before);
            else pass_count++;
            return;
         end
         cyc(H - 6);
         clk_oe_seen = clk_oe_seen | ps2_clk_oe;
         rx[i-1]     = ps2_data_in;
         dev_clk_low = 1'b0;
         cyc(H);
      end

      check_count++;
      if (rx !== exp_frame) $display("FAIL %s frame: sampled %b expected %b", name, rx, exp_frame);
      else pass_count++;
      check_count++;
      if (rx[8] !== exp_par) $display("FAIL %s parity: got %b expected %b", name, rx[8], exp_par);
      else pass_count++;
      check_count++;
      if (clk_oe_seen !== 1'b0) $display("FAIL %s clk_oe_in_shift: got 1 expected 0", name);
      else pass_count++;

      if (ack) dev_data_low = 1'b1;
      cyc(5);
      dev_clk_low = 1'b1;
      cyc(H);
      dev_clk_low = 1'b0;
      cyc(5);
      dev_data_low = 1'b0;

      n = 0;
      while (done_count == done_before && n < 100) begin
         n++;
         @(negedge clk);
      end
      cyc(3);
      check_count++;
      if (done_count !== done_before + 1)
         $display("FAIL %s done_pulse: count got %0d expected %0d", name, done_count, done_before + 1);
      else pass_count++;
      check_count++;
      if (last_err !== !ack) $display("FAIL %s err_with_done: got %b expected %b", name, last_err, !ack);
      else pass_count++;
      check_count++;
      if (err_count !== err_before + (ack ? 0 : 1))
         $display("FAIL %s err_pulses: got %0d expected %0d", name, err_count - err_before, ack ? 0 : 1);
      else pass_count++;
      check_count++;
      if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000)
         $display("FAIL %s idle_after: clk_oe,data_oe,busy got %b expected 000",
                  name, {ps2_clk_oe, ps2_data_oe, tx_busy});
      else pass_count++;
   endtask

   // Device never clocks. The timer passes REQ_TO after REQ_TO+1 cycles in REQ,
   // then FAIL and DONE take one cycle each before tx_done shows.
   task automatic test_req_timeout();
      int n;
      tx_data  = 8'hF4;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         n++;
         @(negedge clk);
      end
      n = 0;
      while (!tx_done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_count++;
      if (n !== REQ_TO + 3) $display("FAIL req_timeout_latency: got %0d expected %0d", n, REQ_TO + 3);
      else pass_count++;
      check_count++;
      if ({tx_done, tx_err} !== 2'b11)
         $display("FAIL req_timeout_err: done,err got %b expected 11", {tx_done, tx_err});
      else pass_count++;
      @(negedge clk);
      check_count++;
      if ({ps2_clk_oe, ps2_data_oe, tx_busy} !== 3'b000)
         $display("FAIL req_timeout_release: clk_oe,data_oe,busy got %b expected 000",
                  {ps2_clk_oe, ps2_data_oe, tx_busy});
      else pass_count++;
   endtask

   task automatic test_set_led();
      run_xfer(8'hED, 1'b1, 1'b1, 0, 0, "set_led");
   endtask

   task automatic test_parity();
      run_xfer(8'h01, 1'b0, 1'b1, 0, 0, "parity_01");
      run_xfer(8'hFF, 1'b1, 1'b1, 0, 0, "parity_ff");
   endtask

   task automatic test_nack();
      run_xfer(8'hED, 1'b1, 1'b0, 0, 0, "nack");
   endtask

   task automatic test_busy_ignore();
      run_xfer(8'hF4, 1'b0, 1'b1, 3, 0, "busy_ignore");
   endtask

   task automatic test_reset_mid();
      run_xfer(8'hED, 1'b1, 1'b1, 0, 5, "rst_mid");
      run_xfer(8'hF4, 1'b0, 1'b1, 0, 0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_set_led();
      test_parity();
      test_nack();
      test_busy_ignore();
      test_req_timeout();
      test_reset_mid();
      cyc(5);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
